// File: rtl/vga_timing_gen_if.sv
// Raster timing bundle carried from vga_timing_gen to the pixel blocks and
// the VGA connector. The generator drives everything (master); consumers
// only observe (slave).
interface vga_timing_gen_if;
   logic [9:0] DrawX;
   logic [9:0] DrawY;
   logic       blank;
   logic       hs;
   logic       vs;
   logic       line_start;
   logic       frame_start;

   modport master (
      output DrawX,
      output DrawY,
      output blank,
      output hs,
      output vs,
      output line_start,
      output frame_start
   );

   modport slave (
      input DrawX,
      input DrawY,
      input blank,
      input hs,
      input vs,
      input line_start,
      input frame_start
   );
endinterface

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: raster timing generator running on the pixel clock.
// hc/vc hold the position that the next clock edge will present; every
// output is decoded from them and registered together, so DrawX, DrawY,
// blank, hs, vs, line_start and frame_start always describe the same pixel.
// Optional macro VGA_SYNC_DELAY_EN: adds one register stage on hs/vs so the
// sync lines line up with colour that downstream blocks register one clock
// after DrawX.
module vga_timing_gen #(
   parameter int H_ACTIVE = 640,
   parameter int H_FP     = 16,
   parameter int H_SYNC   = 96,
   parameter int H_BP     = 48,
   parameter int V_ACTIVE = 480,
   parameter int V_FP     = 10,
   parameter int V_SYNC   = 2,
   parameter int V_BP     = 33,
   parameter bit HS_POL   = 1'b0,
   parameter bit VS_POL   = 1'b0
) (
   input logic               vga_clk,
   input logic               reset,
   vga_timing_gen_if.master  vga
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

   // 11-bit compare constants so a region ending exactly at 1024 still works
   localparam logic [9:0]  H_LAST       = 10'(H_TOTAL - 1);
   localparam logic [9:0]  V_LAST       = 10'(V_TOTAL - 1);
   localparam logic [10:0] H_ACT_END    = 11'(H_ACTIVE);
   localparam logic [10:0] V_ACT_END    = 11'(V_ACTIVE);
   localparam logic [10:0] H_SYNC_START = 11'(H_ACTIVE + H_FP);
   localparam logic [10:0] H_SYNC_END   = 11'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [10:0] V_SYNC_START = 11'(V_ACTIVE + V_FP);
   localparam logic [10:0] V_SYNC_END   = 11'(V_ACTIVE + V_FP + V_SYNC);

   if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_bad_totals
      $error("vga_timing_gen: H_TOTAL and V_TOTAL must not exceed 1024");
   end

   logic [9:0] hc, vc;
   logic [9:0] hc_next, vc_next;
   logic       blank_d, hs_d, vs_d, line_start_d, frame_start_d;

   logic [9:0] draw_x_q, draw_y_q;
   logic       blank_q, hs_q, vs_q, line_start_q, frame_start_q;

   // Advance the raster position and decode the pixel about to be presented
   always_comb begin
      hc_next = hc + 10'd1;
      vc_next = vc;
      if (hc == H_LAST) begin
         hc_next = 10'd0;
         if (vc == V_LAST) begin
            vc_next = 10'd0;
         end else begin
            vc_next = vc + 10'd1;
         end
      end

      blank_d       = ({1'b0, hc} < H_ACT_END) && ({1'b0, vc} < V_ACT_END);
      hs_d          = (({1'b0, hc} >= H_SYNC_START) && ({1'b0, hc} < H_SYNC_END))
                      ? HS_POL : ~HS_POL;
      vs_d          = (({1'b0, vc} >= V_SYNC_START) && ({1'b0, vc} < V_SYNC_END))
                      ? VS_POL : ~VS_POL;
      line_start_d  = (hc == 10'd0);
      frame_start_d = (hc == 10'd0) && (vc == 10'd0);
   end

   // Counter and output registers; reset snaps straight back to (0,0)
   always_ff @(posedge vga_clk) begin
      if (reset) begin
         hc            <= 10'd0;
         vc            <= 10'd0;
         draw_x_q      <= 10'd0;
         draw_y_q      <= 10'd0;
         blank_q       <= 1'b0;
         hs_q          <= ~HS_POL;
         vs_q          <= ~VS_POL;
         line_start_q  <= 1'b0;
         frame_start_q <= 1'b0;
      end else begin
         hc            <= hc_next;
         vc            <= vc_next;
         draw_x_q      <= hc;
         draw_y_q      <= vc;
         blank_q       <= blank_d;
         hs_q          <= hs_d;
         vs_q          <= vs_d;
         line_start_q  <= line_start_d;
         frame_start_q <= frame_start_d;
      end
   end

   assign vga.DrawX       = draw_x_q;
   assign vga.DrawY       = draw_y_q;
   assign vga.blank       = blank_q;
   assign vga.line_start  = line_start_q;
   assign vga.frame_start = frame_start_q;

`ifdef VGA_SYNC_DELAY_EN
   logic hs_dly, vs_dly;

   // Extra sync stage so hs/vs match the one-clock lag of registered colour
   always_ff @(posedge vga_clk) begin
      if (reset) begin
         hs_dly <= ~HS_POL;
         vs_dly <= ~VS_POL;
      end else begin
         hs_dly <= hs_q;
         vs_dly <= vs_q;
      end
   end

   assign vga.hs = hs_dly;
   assign vga.vs = vs_dly;
`else
   assign vga.hs = hs_q;
   assign vga.vs = vs_q;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: a default 640x480 instance and a tiny 12x7
// instance share one clock and one randomly pulsed reset. A reference model
// derives every expected output from the raster index counted since reset
// release, using plain division/modulo on the timing parameters.
module tb_vga_timing_gen;

   logic vga_clk;
   logic reset;

   int vectors;
   int miscompares;
   int n;

   vga_timing_gen_if if_def ();
   vga_timing_gen_if if_small ();

   vga_timing_gen dut_def (
      .vga_clk (vga_clk),
      .reset   (reset),
      .vga     (if_def)
   );

   vga_timing_gen #(
      .H_ACTIVE (8),
      .H_FP     (1),
      .H_SYNC   (2),
      .H_BP     (1),
      .V_ACTIVE (4),
      .V_FP     (1),
      .V_SYNC   (1),
      .V_BP     (1),
      .HS_POL   (1'b0),
      .VS_POL   (1'b0)
   ) dut_small (
      .vga_clk (vga_clk),
      .reset   (reset),
      .vga     (if_small)
   );

   // Pixel clock
   initial vga_clk = 1'b0;
   always #5 vga_clk = ~vga_clk;

   // Compare one observed value against the model and tally the result
   task automatic checkOutput(input string tag, input int observed, input int expected);
      vectors++;
      if (observed != expected) begin
         miscompares++;
         $display("[TB] FAIL %s: got %0d, expected %0d (raster index %0d)", tag, observed, expected, n);
      end
   endtask

   // Asserted level of a sync signal for raster index idx (idx < 0 = reset)
   function automatic int syncActive(input int idx, input int total, input int divisor,
                                     input int modulus, input int first, input int width);
      int pos;
      if (idx < 0) return 0;
      pos = (idx / divisor) % modulus;
      return ((pos >= first) && (pos < first + width)) ? 1 : 0;
   endfunction

   // Model one instance at raster index n and compare all of its outputs
   task automatic checkRaster(input string name,
                              input int ha, input int hfp, input int hsw, input int hbp,
                              input int va, input int vfp, input int vsw, input int vbp,
                              input logic [9:0] dx, input logic [9:0] dy, input logic bl,
                              input logic h, input logic v, input logic ls, input logic fs);
      int ht, vt, x, y, sidx, exp_hs, exp_vs;
      ht = ha + hfp + hsw + hbp;
      vt = va + vfp + vsw + vbp;
      if (n < 0) begin
         x = 0;
         y = 0;
         checkOutput({name, ".blank"}, int'(bl), 0);
         checkOutput({name, ".line_start"}, int'(ls), 0);
         checkOutput({name, ".frame_start"}, int'(fs), 0);
      end else begin
         x = n % ht;
         y = (n / ht) % vt;
         checkOutput({name, ".blank"}, int'(bl), ((x < ha) && (y < va)) ? 1 : 0);
         checkOutput({name, ".line_start"}, int'(ls), (x == 0) ? 1 : 0);
         checkOutput({name, ".frame_start"}, int'(fs), ((x == 0) && (y == 0)) ? 1 : 0);
      end
      checkOutput({name, ".DrawX"}, int'(dx), x);
      checkOutput({name, ".DrawY"}, int'(dy), y);
`ifdef VGA_SYNC_DELAY_EN
      sidx = (n < 0) ? -1 : n - 1;
`else
      sidx = n;
`endif
      // both polarities are active-low in these instances
      exp_hs = 1 - syncActive(sidx, ht, 1, ht, ha + hfp, hsw);
      exp_vs = 1 - syncActive(sidx, ht, ht, vt, va + vfp, vsw);
      checkOutput({name, ".hs"}, int'(h), exp_hs);
      checkOutput({name, ".vs"}, int'(v), exp_vs);
   endtask

   // Reference raster index: -1 while in reset, counts up from 0 after release
   initial n = -2;
   always @(posedge vga_clk) begin
      if (reset) begin
         n <= -1;
      end else if (n >= -1) begin
         n <= n + 1;
      end
   end

   // Sample both instances on the falling edge, away from register updates
   always @(negedge vga_clk) begin
      if (n >= -1) begin
         checkRaster("def", 640, 16, 96, 48, 480, 10, 2, 33,
                     if_def.DrawX, if_def.DrawY, if_def.blank, if_def.hs, if_def.vs,
                     if_def.line_start, if_def.frame_start);
         checkRaster("small", 8, 1, 2, 1, 4, 1, 1, 1,
                     if_small.DrawX, if_small.DrawY, if_small.blank, if_small.hs, if_small.vs,
                     if_small.line_start, if_small.frame_start);
      end
   end

   // Free-run for a number of clocks, then pulse reset for a random length
   task automatic applyStimulus(input int run_cycles, input int reset_cycles);
      repeat (run_cycles) @(negedge vga_clk);
      reset = 1'b1;
      repeat (reset_cycles) @(negedge vga_clk);
      reset = 1'b0;
   endtask

   // Power-on reset, long runs across line/frame wraps, random mid-frame resets
   initial begin
      vectors     = 0;
      miscompares = 0;
      reset       = 1'b1;
      repeat (3) @(negedge vga_clk);
      reset = 1'b0;
      applyStimulus(2600, 1);
      for (int k = 0; k < 12; k++) begin
         applyStimulus(int'($urandom_range(20, 1200)), int'($urandom_range(1, 3)));
      end
      applyStimulus(1700, 2);
      repeat (200) @(negedge vga_clk);
      $display("[TB] == %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Raster timing generator that produces DrawX, DrawY and blank for the palettized sprite and pixel blocks.
- Drives hs and vs to the VGA connector.
- Runs on the pixel clock; one clock cycle equals one pixel.
- Default timing is 640x480 at 60 Hz: 800 clocks per line, 525 lines per frame.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch in clocks
- H_SYNC, 96, horizontal sync width in clocks
- H_BP, 48, horizontal back porch in clocks
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch in lines
- V_SYNC, 2, vertical sync width in lines
- V_BP, 33, vertical back porch in lines
- HS_POL, 0, asserted level of hs (0 = active-low)
- VS_POL, 0, asserted level of vs (0 = active-low)

Ports:
- vga_clk  in  1  pixel clock; all logic on posedge
- reset  in  1  synchronous, active-high reset
- DrawX  out  10  current horizontal position, 0..H_TOTAL-1
- DrawY  out  10  current vertical position, 0..V_TOTAL-1
- blank  out  1  1 = visible region (pixel blocks drive colour), 0 = blanking
- hs  out  1  horizontal sync
- vs  out  1  vertical sync
- line_start  out  1  one-cycle pulse when DrawX = 0
- frame_start  out  1  one-cycle pulse when DrawX = 0 and DrawY = 0

Behaviour:
- Derived totals:
  - H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP.
  - V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP.
  - Both totals must be ≤ 1024; elaboration error otherwise.
- Internal state: 10-bit counters hc and vc. All outputs are registered and decoded from the next counter values, so every output describes the same raster position in the same cycle.
- Reset (any posedge with reset=1, including mid-frame):
  - hc=0, vc=0.
  - Outputs forced to DrawX=0, DrawY=0, blank=0, hs=~HS_POL, vs=~VS_POL, line_start=0, frame_start=0.
  - Position returns to (0,0) immediately; no partial line is completed.
- First posedge with reset=0:
  - Outputs show position (0,0): blank=1, line_start=1, frame_start=1.
  - On the Nth edge after release, outputs show raster index N-1 (row-major).
- Counting:
  - hc increments every clock.
  - At hc=H_TOTAL-1, hc wraps to 0 and vc increments.
  - At hc=H_TOTAL-1 and vc=V_TOTAL-1 simultaneously, both wrap to 0.
  - No clock enable; the generator never stalls.
- Output decode:
  - DrawX=hc and DrawY=vc over their full range. Values keep counting through the blanking regions; consumers must gate on blank.
  - blank = (hc < H_ACTIVE) && (vc < V_ACTIVE).
  - hs = HS_POL when H_ACTIVE+H_FP ≤ hc < H_ACTIVE+H_FP+H_SYNC (default 656..751), else ~HS_POL.
  - vs = VS_POL when V_ACTIVE+V_FP ≤ vc < V_ACTIVE+V_FP+V_SYNC (default 490..491), else ~VS_POL. vs changes only at line boundaries (hc=0).
  - line_start = (hc==0); frame_start = (hc==0 && vc==0).
- Latency: zero cycles between DrawX/DrawY and blank/hs/vs (all describe the same pixel) unless the optional feature is enabled.
- Pixel-block contract: downstream blocks register colour one cycle after DrawX, so their colour output lags by one clock. The optional feature compensates for this lag on the sync lines.

Optional Feature:
- Macro VGA_SYNC_DELAY_EN.
- When defined:
  - hs and vs pass through one extra register stage, so they lag DrawX/DrawY/blank by exactly 1 clock and align with registered colour.
  - Default hs asserts on the edge after DrawX=656 and deasserts on the edge after DrawX=752.
  - The delay stage also resets synchronously to ~HS_POL/~VS_POL.
  - DrawX, DrawY, blank, line_start and frame_start are unchanged.
- When undefined: hs and vs are aligned with DrawX as described in Behaviour.

Test Plan:
- Reset held 3 cycles then released -> outputs are reset values while reset=1; first edge after release shows DrawX=0, DrawY=0, blank=1, line_start=1, frame_start=1, hs=1, vs=1.
- Run 1 full line -> blank=1 for DrawX 0..639 and 0 for 640..799; hs=0 for exactly 96 clocks at DrawX 656..751; line_start repeats every 800 clocks.
- Run 1 full frame -> DrawY steps 0..524 then wraps to 0 with DrawX; vs=0 exactly while DrawY=490..491 (1600 clocks); frame_start pulses once per 420000 clocks.
- Assert reset for 1 cycle at DrawX=300, DrawY=200 -> next edge shows reset values; the following edge shows (0,0) with frame_start=1.
- Build with VGA_SYNC_DELAY_EN -> hs falls on the edge after DrawX=656 and rises on the edge after DrawX=752; blank transition at DrawX=640 is unchanged.
- Small parameter set (H: 8/1/2/1, V: 4/1/1/1) -> H_TOTAL=12, V_TOTAL=7; hs asserted at DrawX 9..10; vs asserted at DrawY 5; wrap after 84 clocks.
